// File: rtl/epd_frame_scheduler.sv
// ---------------------------------------------------------------------------
// epd_frame_scheduler
//
// Sequences the EPD scan engine through a waveform update. A request
// (frame count + LUT ID) is taken from the host path; one scan_start pulse is
// issued per frame, and scan_done from the scan engine is awaited before the
// next frame. A fixed idle gap separates consecutive frames. One further
// request can be queued in a single-entry pending slot. An abort lets the
// current frame finish and then ends the update. A watchdog flags a scan
// engine that never answers.
//
// Handshake: a request transfers on any rising clk edge where
// req_valid & req_ready are both high. req_ready does not depend on
// req_valid. The requester holds req_frames/req_lut_id stable while
// req_valid is high.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     request valid            (in)
//   req_ready     request can be accepted  (out)
//   req_frames    frames in the update, 0 = no-op (in)
//   req_lut_id    LUT select for the update (in)
//   abort         pulse: end after current frame, drop pending (in)
//   scan_start    pulse: scan engine begins one frame (out)
//   scan_done     pulse: scan engine finished the frame (in)
//   frame_index   0-based index of the frame being scanned (out)
//   lut_id        LUT ID of the active update (out)
//   active        update in progress (out)
//   upd_done      pulse: update complete (out)
//   upd_aborted   qualifies upd_done: update ended by abort (out)
//   timeout_err   sticky watchdog error, cleared only by rst (out)
//   state_dbg     current FSM state encoding (out)
// ---------------------------------------------------------------------------
module epd_frame_scheduler #(
    parameter int FCNT_W     = 6,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1 << 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FCNT_W-1:0] req_frames,
    input  logic              req_lut_id,
    input  logic              abort,
    output logic              scan_start,
    input  logic              scan_done,
    output logic [FCNT_W-1:0] frame_index,
    output logic              lut_id,
    output logic              active,
    output logic              upd_done,
    output logic              upd_aborted,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [FCNT_W-1:0] frames_q;
    logic [FCNT_W-1:0] index_q;
    logic              lut_q;
    logic              pend_valid;
    logic [FCNT_W-1:0] pend_frames;
    logic              pend_lut;
    logic              abort_l;
    logic [WD_W-1:0]   wdog;
    logic [GAP_W-1:0]  gap_cnt;

    logic accept;
    logic abort_now;
    logic last_frame;
    logic wdog_expired;
    logic pend_load;

    assign req_ready    = !pend_valid && !timeout_err;
    assign accept       = req_valid && req_ready;
    // An abort arriving in the same cycle as scan_done still ends the update.
    assign abort_now    = abort_l || abort;
    // frames_q is always >= 1 while a frame is scanned, so this never wraps.
    assign last_frame   = (index_q + 1'b1) == frames_q;
    assign wdog_expired = wdog == WD_W'(TIMEOUT - 1);
    // FINISH hands over to the queued update unless an abort drops it now.
    assign pend_load    = pend_valid && !abort;

    assign frame_index  = index_q;
    assign lut_id       = lut_q;
    assign active       = (state != S_IDLE);
    assign state_dbg    = state;

    always_comb begin
        state_n     = state;
        scan_start  = 1'b0;
        upd_done    = 1'b0;
        upd_aborted = 1'b0;
        case (state)
            S_IDLE: begin
                // A slot filled during FINISH is loaded here like a new request.
                if (pend_valid) begin
                    state_n = (pend_frames == '0) ? S_FINISH : S_START;
                end else if (accept) begin
                    state_n = (req_frames == '0) ? S_FINISH : S_START;
                end
            end
            S_START: begin
                scan_start = 1'b1;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (scan_done) begin
                    state_n = (last_frame || abort_now) ? S_FINISH : S_GAP;
                end else if (wdog_expired) begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort_now) begin
                    state_n = S_FINISH;
                end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_n = S_START;
                end
            end
            S_FINISH: begin
                upd_done    = 1'b1;
                upd_aborted = abort_l;
                if (pend_load) begin
                    state_n = (pend_frames == '0) ? S_FINISH : S_GAP;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            frames_q    <= '0;
            index_q     <= '0;
            lut_q       <= 1'b0;
            pend_valid  <= 1'b0;
            pend_frames <= '0;
            pend_lut    <= 1'b0;
            abort_l     <= 1'b0;
            wdog        <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_n;
            wdog    <= (state == S_WAIT) ? wdog + 1'b1 : '0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;

            // Outside IDLE a request is parked in the slot.
            if (accept && state != S_IDLE) begin
                pend_valid  <= 1'b1;
                pend_frames <= req_frames;
                pend_lut    <= req_lut_id;
            end
            // Abort wins over a request accepted in the same cycle.
            if (abort && state != S_IDLE) begin
                abort_l    <= 1'b1;
                pend_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pend_valid) begin
                        frames_q   <= pend_frames;
                        lut_q      <= pend_lut;
                        index_q    <= '0;
                        pend_valid <= 1'b0;
                    end else if (accept) begin
                        frames_q <= req_frames;
                        lut_q    <= req_lut_id;
                        index_q  <= '0;
                    end
                end
                S_WAIT: begin
                    if (scan_done) begin
                        if (!last_frame && !abort_now) begin
                            index_q <= index_q + 1'b1;
                        end
                    end else if (wdog_expired) begin
                        timeout_err <= 1'b1;
                        pend_valid  <= 1'b0;
                        abort_l     <= 1'b0;
                    end
                end
                S_FINISH: begin
                    abort_l <= 1'b0;
                    if (pend_load) begin
                        frames_q   <= pend_frames;
                        lut_q      <= pend_lut;
                        index_q    <= '0;
                        pend_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_epd_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_epd_frame_scheduler
//
// Directed bench for epd_frame_scheduler with a short gap and watchdog.
// Inputs are driven and outputs observed 1 time unit after each rising edge;
// "cycle" below is the number of rising edges seen so far.
// ---------------------------------------------------------------------------
module tb_epd_frame_scheduler;

    localparam int FCNT_W = 6;
    localparam int GAP    = 5;
    localparam int TO     = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [FCNT_W-1:0] req_frames = '0;
    logic              req_lut_id = 1'b0;
    logic              abort = 1'b0;
    logic              scan_start;
    logic              scan_done = 1'b0;
    logic [FCNT_W-1:0] frame_index;
    logic              lut_id;
    logic              active;
    logic              upd_done;
    logic              upd_aborted;
    logic              timeout_err;
    logic [2:0]        state_dbg;

    // Expected {lut_id, frame_index} for each scan_start, in order.
    logic [FCNT_W:0] exp_q[$];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int done_pulses = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int last_done = -1;

    epd_frame_scheduler #(
        .FCNT_W(FCNT_W),
        .GAP_CYCLES(GAP),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_frames(req_frames),
        .req_lut_id(req_lut_id),
        .abort(abort),
        .scan_start(scan_start),
        .scan_done(scan_done),
        .frame_index(frame_index),
        .lut_id(lut_id),
        .active(active),
        .upd_done(upd_done),
        .upd_aborted(upd_aborted),
        .timeout_err(timeout_err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (upd_done) done_pulses <= done_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int frames, input logic lut);
        int n = 0;
        req_valid  = 1'b1;
        req_frames = FCNT_W'(frames);
        req_lut_id = lut;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("req_accept_timeout", 0, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        while (!scan_start && n < max) begin
            step();
            n++;
        end
        check("scan_start_seen", scan_start, 1);
        start_cyc = cyc;
    endtask

    // Scan engine: wait for scan_start, check the presented frame, answer
    // with scan_done after 'delay' cycles. Leaves the bench one cycle after
    // scan_done.
    task automatic run_frame(input int delay);
        int starts = 0;
        logic [FCNT_W:0] e;
        wait_start(100);
        if (last_done >= 0) check("gap_timing", start_cyc - last_done, GAP + 1);
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("frame_index", frame_index, e[FCNT_W-1:0]);
            check("lut_id", lut_id, e[FCNT_W]);
        end
        for (int i = 0; i < delay; i++) begin
            step();
            starts += scan_start;
        end
        check("no_restart_before_done", starts, 0);
        check("index_stable_in_wait", frame_index, e[FCNT_W-1:0]);
        scan_done = 1'b1;
        done_cyc  = cyc;
        step();
        scan_done = 1'b0;
        last_done = done_cyc;
    endtask

    task automatic push_frames(input int n, input logic lut);
        for (int i = 0; i < n; i++) exp_q.push_back({lut, FCNT_W'(i)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int cnt;

        repeat (3) step();
        check("rst_req_ready", req_ready, 1);
        check("rst_active", active, 0);
        check("rst_scan_start", scan_start, 0);
        check("rst_frame_index", frame_index, 0);
        check("rst_lut_id", lut_id, 0);
        check("rst_upd_done", upd_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        step();

        // 3-frame update, LUT 1, stray scan_done injected in the first gap.
        push_frames(3, 1'b1);
        last_done = -1;
        send_req(3, 1'b1);
        check("t1_idle_latency", scan_start, 1);
        check("t1_active", active, 1);
        run_frame(3);
        scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        check("t2_stray_done_index", frame_index, 1);
        run_frame(2);
        run_frame(4);
        check("t1_upd_done", upd_done, 1);
        check("t1_upd_aborted", upd_aborted, 0);
        step();
        check("t1_upd_done_pulse", upd_done, 0);
        check("t1_active_low", active, 0);
        check("t1_req_ready", req_ready, 1);

        // Zero-frame request: no scan, immediate completion.
        p = done_pulses;
        send_req(0, 1'b0);
        check("t3_upd_done", upd_done, 1);
        check("t3_no_scan_start", scan_start, 0);
        check("t3_active_finish", active, 1);
        step();
        check("t3_active_low", active, 0);
        check("t3_upd_done_pulse", upd_done, 0);
        check("t3_done_count", done_pulses - p, 1);

        // 5-frame update with a queued 2-frame update; a third request held off.
        push_frames(5, 1'b1);
        last_done = -1;
        send_req(5, 1'b1);
        run_frame(2);
        send_req(2, 1'b0);
        check("t4_ready_pend_full", req_ready, 0);
        req_valid  = 1'b1;
        req_frames = FCNT_W'(7);
        req_lut_id = 1'b1;
        run_frame(2);
        check("t4_third_held_off", req_ready, 0);
        req_valid = 1'b0;
        run_frame(2);
        run_frame(2);
        run_frame(2);
        check("t4_upd_done", upd_done, 1);
        check("t4_upd_aborted", upd_aborted, 0);
        push_frames(2, 1'b0);
        last_done = done_cyc + 1;
        run_frame(2);
        run_frame(3);
        check("t4_pend_upd_done", upd_done, 1);
        step();
        check("t4_active_low", active, 0);

        // Abort during frame 1 of 4 with a pending request queued.
        push_frames(1, 1'b0);
        last_done = -1;
        send_req(4, 1'b0);
        run_frame(2);
        send_req(3, 1'b1);
        check("t5_ready_pend_full", req_ready, 0);
        wait_start(100);
        check("t5_frame_index", frame_index, 1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_drops_pend", req_ready, 1);
        check("t5_frame_continues", active, 1);
        step();
        step();
        scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        check("t5_upd_done", upd_done, 1);
        check("t5_upd_aborted", upd_aborted, 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            cnt += scan_start + active;
        end
        check("t5_no_more_activity", cnt, 0);

        // Reset mid-update: straight to IDLE, no completion.
        send_req(3, 1'b0);
        step();
        step();
        p = done_pulses;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_active", active, 0);
        check("t6_rst_scan_start", scan_start, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt += scan_start;
        end
        check("t6_rst_no_start", cnt, 0);
        check("t6_rst_no_done", done_pulses - p, 0);

        // Watchdog: scan_done withheld. The counter expires in the TO-th
        // cycle after scan_start; the sticky flag shows up one cycle later.
        send_req(2, 1'b1);
        wait_start(10);
        p = done_pulses;
        cnt = 0;
        while (!timeout_err && cnt < 200) begin
            step();
            cnt++;
        end
        check("t7_timeout_delay", cyc - start_cyc, TO + 1);
        check("t7_idle", active, 0);
        check("t7_req_ready", req_ready, 0);
        check("t7_no_upd_done", done_pulses - p, 0);
        req_valid  = 1'b1;
        req_frames = FCNT_W'(1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += active + scan_start;
        end
        req_valid = 1'b0;
        check("t7_blocked", cnt, 0);
        check("t7_sticky", timeout_err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t7_rst_clears", timeout_err, 0);
        check("t7_rst_ready", req_ready, 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
